// File: rtl/program_sequencer.sv
// Runs NUM_PROGS core programs back to back from one Go request, timing each
// program and ending the run with TimeoutErr if one exceeds the watchdog limit.
module program_sequencer #(
  parameter int NUM_PROGS  = 3,
  parameter int PC_W       = 10,
  parameter int ADDR0      = 0,
  parameter int ADDR1      = 128,
  parameter int ADDR2      = 256,
  parameter int START_CYC  = 2,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 16'hFFF0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Ack,
  output logic             CoreStart,
  output logic [PC_W-1:0]  StartAddr,
  output logic [1:0]       ProgIdx,
  output logic             Busy,
  output logic             ProgDone,
  output logic [CNT_W-1:0] LastCycles,
  output logic             AllDone,
  output logic             TimeoutErr,
  output logic [2:0]       state_dbg
);

  // Core handshake: CoreStart is held for START_CYC cycles with StartAddr valid
  // throughout; the core answers with a level Ack. An Ack counts only after
  // the core has been seen low at least once in RUN, so a level left high by the
  // previous program cannot complete the new one.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_RECORD = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam int LC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [LC_W-1:0]  LAUNCH_LAST = LC_W'(START_CYC - 1);
  localparam logic [1:0]       LAST_IDX    = 2'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] LIMIT       = CNT_W'(WDOG_LIMIT);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [LC_W-1:0]  lcnt_q, lcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             arm_q, arm_d;
  logic [CNT_W-1:0] last_q, last_d;

  logic             core_start_q;
  logic [PC_W-1:0]  addr_q;
  logic             busy_q;
  logic             done_q;
  logic             all_done_q;
  logic             err_q;

  function automatic logic [PC_W-1:0] entry_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    entry_addr = PC_W'(ADDR0);
      2'd1:    entry_addr = PC_W'(ADDR1);
      default: entry_addr = PC_W'(ADDR2);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lcnt_d  = lcnt_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    last_d  = last_q;
    // The value for the current RUN cycle, so a completing cycle is counted.
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Go) begin
          state_d = S_LAUNCH;
          idx_d   = '0;
          lcnt_d  = '0;
        end
      end
      S_LAUNCH: begin
        if (lcnt_q == LAUNCH_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          arm_d   = 1'b0;
        end else begin
          lcnt_d = lcnt_q + LC_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (!Ack) arm_d = 1'b1;
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (Ack && arm_q) begin
          state_d = S_RECORD;
          last_d  = cnt_inc;
        end else if (cnt_inc >= LIMIT) begin
          state_d = S_ERROR;
        end
      end
      S_RECORD: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LAUNCH;
          idx_d   = idx_q + 2'd1;
          lcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      lcnt_q       <= '0;
      cnt_q        <= '0;
      arm_q        <= 1'b0;
      last_q       <= '0;
      core_start_q <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      all_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lcnt_q       <= lcnt_d;
      cnt_q        <= cnt_d;
      arm_q        <= arm_d;
      last_q       <= last_d;
      core_start_q <= (state_d == S_LAUNCH);
      addr_q       <= (state_d == S_LAUNCH) ? entry_addr(idx_d) : '0;
      busy_q       <= (state_d == S_LAUNCH) || (state_d == S_RUN) ||
                      (state_d == S_RECORD);
      done_q       <= (state_d == S_RECORD);
      all_done_q   <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERROR);
    end
  end

  assign CoreStart  = core_start_q;
  assign StartAddr  = addr_q;
  assign ProgIdx    = idx_q;
  assign Busy       = busy_q;
  assign ProgDone   = done_q;
  assign LastCycles = last_q;
  assign AllDone    = all_done_q;
  assign TimeoutErr = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a per-cycle expected trace is built from ack
// patterns per program, then replayed against the DUT and compared cycle by cycle.
module tb_program_sequencer;

  localparam int NP    = 3;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int SC    = 2;
  localparam int LIM   = 50;
  localparam int W     = 1 + PC_W + 2 + 1 + 1 + CNT_W + 1 + 1;

  logic             clk = 1'b0;
  logic             reset, go, ack;
  logic             core_start;
  logic [PC_W-1:0]  start_addr;
  logic [1:0]       prog_idx;
  logic             busy, prog_done, all_done, timeout_err;
  logic [CNT_W-1:0] last_cycles;
  logic [2:0]       state_dbg;

  program_sequencer #(
    .NUM_PROGS(NP), .PC_W(PC_W), .ADDR0(0), .ADDR1(128), .ADDR2(256),
    .START_CYC(SC), .CNT_W(CNT_W), .WDOG_LIMIT(LIM)
  ) dut (
    .Clk(clk), .Reset(reset), .Go(go), .Ack(ack),
    .CoreStart(core_start), .StartAddr(start_addr), .ProgIdx(prog_idx),
    .Busy(busy), .ProgDone(prog_done), .LastCycles(last_cycles),
    .AllDone(all_done), .TimeoutErr(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  logic         ack_q[$];
  logic         go_q[$];
  logic         rst_q[$];
  string        tag_q[$];

  logic [PC_W-1:0]  addr_tab [NP] = '{10'd0, 10'd128, 10'd256};
  int               plan_stale [NP];
  int               plan_ack [NP];

  // Reference model state between runs: 0 idle, 1 done, 2 error.
  int               m_kind = 0;
  logic [1:0]       m_idx  = 2'd0;
  logic [CNT_W-1:0] m_last = '0;

  function automatic logic [W-1:0] pack(input logic cs, input logic [PC_W-1:0] addr,
                                        input logic [1:0] idx, input logic bsy,
                                        input logic pd, input logic [CNT_W-1:0] last,
                                        input logic ad, input logic to);
    return {cs, addr, idx, bsy, pd, last, ad, to};
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Core model: Ack is high for the first `stale` RUN cycles and from RUN
  // cycle `ack_at` on (0 means the core never answers).
  function automatic logic ack_val(input int stale, input int ack_at, input int k);
    return (k <= stale) || (ack_at != 0 && k >= ack_at);
  endfunction

  // The program completes on the first RUN cycle with Ack high that follows
  // some earlier RUN cycle with Ack low, provided it is within the limit.
  function automatic int done_cycle(input int stale, input int ack_at);
    bit seen_low = 1'b0;
    for (int k = 1; k <= LIM; k++) begin
      if (ack_val(stale, ack_at, k) && seen_low) return k;
      if (!ack_val(stale, ack_at, k)) seen_low = 1'b1;
    end
    return 0;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [W-1:0] quiet_vec();
    if (m_kind == 1) return pack(1'b0, '0, 2'(NP - 1), 1'b0, 1'b0, m_last, 1'b1, 1'b0);
    if (m_kind == 2) return pack(1'b0, '0, m_idx, 1'b0, 1'b0, m_last, 1'b0, 1'b1);
    return pack(1'b0, '0, 2'd0, 1'b0, 1'b0, m_last, 1'b0, 1'b0);
  endfunction

  task automatic push(input string tag, input logic [W-1:0] e, input logic a,
                      input logic g, input logic r);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    ack_q.push_back(a);
    go_q.push_back(g);
    rst_q.push_back(r);
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++) push("quiet", quiet_vec(), rnd(), 1'b0, 1'b0);
  endtask

  // One Go-initiated run; noise pulses Go while busy, abort_at (>0) asserts
  // Reset on that RUN cycle of the last program.
  task automatic gen_run(input bit noise, input int abort_at);
    push("go", quiet_vec(), rnd(), 1'b1, 1'b0);
    for (int p = 0; p < NP; p++) begin
      int dc;
      logic [W-1:0] run_v;
      dc = done_cycle(plan_stale[p], plan_ack[p]);
      for (int c = 0; c < SC; c++)
        push("launch", pack(1'b1, addr_tab[p], 2'(p), 1'b1, 1'b0, m_last, 1'b0, 1'b0),
             (plan_stale[p] > 0) ? 1'b1 : rnd(), noise ? rnd() : 1'b0, 1'b0);
      run_v = pack(1'b0, '0, 2'(p), 1'b1, 1'b0, m_last, 1'b0, 1'b0);
      for (int k = 1; k <= LIM; k++) begin
        if (p == NP - 1 && k == abort_at) begin
          push("run", run_v, ack_val(plan_stale[p], plan_ack[p], k), 1'b0, 1'b1);
          m_kind = 0; m_idx = 2'd0; m_last = '0;
          return;
        end
        push("run", run_v, ack_val(plan_stale[p], plan_ack[p], k), noise ? rnd() : 1'b0, 1'b0);
        if (k == dc) break;
      end
      if (dc == 0) begin
        m_kind = 2;
        m_idx  = 2'(p);
        return;
      end
      m_last = CNT_W'(dc);
      push("record", pack(1'b0, '0, 2'(p), 1'b1, 1'b1, m_last, 1'b0, 1'b0),
           1'b1, noise ? rnd() : 1'b0, 1'b0);
    end
    m_kind = 1;
  endtask

  task automatic set_plans(input int s0, input int a0, input int s1, input int a1,
                           input int s2, input int a2);
    plan_stale[0] = s0; plan_ack[0] = a0;
    plan_stale[1] = s1; plan_ack[1] = a1;
    plan_stale[2] = s2; plan_ack[2] = a2;
  endtask

  task automatic play();
    logic [W-1:0] e;
    string        t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(negedge clk);
      cyc++;
      check_eq(t, {core_start, start_addr, prog_idx, busy, prog_done,
                   last_cycles, all_done, timeout_err}, e);
      ack   = ack_q.pop_front();
      go    = go_q.pop_front();
      reset = rst_q.pop_front();
    end
  endtask

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    ack   = 1'b0;

    // Nominal run: 20-cycle programs, then the same again from DONE with Go noise.
    set_plans(0, 20, 0, 20, 0, 20);
    gen_run(1'b0, 0);
    gen_idle(3);
    gen_run(1'b1, 0);
    gen_idle(2);
    // Stale Ack held over from the previous program for 3 RUN cycles.
    set_plans(3, 14, 3, 14, 3, 14);
    gen_run(1'b0, 0);
    gen_idle(2);
    // Program 1 never answers: watchdog.
    set_plans(0, 20, 0, 0, 0, 20);
    gen_run(1'b0, 0);
    gen_idle(3);
    // Restart from ERROR; program 0 acks exactly on the limit cycle.
    set_plans(0, LIM, 2, 30, 0, 7);
    gen_run(1'b0, 0);
    gen_idle(2);
    // Reset during RUN of the last program.
    set_plans(0, 20, 0, 20, 0, 20);
    gen_run(1'b0, 8);
    gen_idle(2);
    // Stale Ack that never drops times out even though Ack is high.
    set_plans(0, 5, 60, 0, 0, 5);
    gen_run(1'b1, 0);
    gen_idle(2);
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NP; p++) begin
        plan_stale[p] = $urandom_range(0, 4);
        plan_ack[p]   = $urandom_range(0, 55);
      end
      gen_run(rnd(), (r == 5) ? int'($urandom_range(1, 10)) : 0);
      gen_idle($urandom_range(1, 3));
    end

    repeat (2) @(negedge clk);
    check_eq("reset", {core_start, start_addr, prog_idx, busy, prog_done,
                       last_cycles, all_done, timeout_err}, '0);
    reset = 1'b0;
    play();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
